// File: rtl/ct_f_spsram_param_clr.sv
// Parametrised single-port SRAM: banked write enables, post-reset clear sequencer, held read port.
// Optional extra output register stage when CT_SPSRAM_OUT_FLOP_EN is defined (read latency 2).
module ct_f_spsram_param_clr #(
  parameter int DATA_WIDTH = 196,
  parameter int ADDR_WIDTH = 8,
  parameter int BANK_WIDTH = 48
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  CLR_BUSY
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int NUM_BANKS = (DATA_WIDTH + BANK_WIDTH - 1) / BANK_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  typedef enum logic [0:0] {
    ST_CLR  = 1'b0,
    ST_IDLE = 1'b1
  } clr_state_e;

  clr_state_e state_q;
  clr_state_e state_n;

  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_n;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] q_q;
  logic                  clr_busy;
  logic                  ext_wr;
  logic                  ext_rd;
  logic                  unused_wen;

  // Only each bank's MSB enable is architectural; the rest are don't-care.
  assign unused_wen = ^WEN;

  assign clr_busy = (state_q == ST_CLR);
  assign CLR_BUSY = clr_busy;

  assign ext_wr = ~CEN & ~GWEN & ~clr_busy;
  assign ext_rd = ~CEN &  GWEN & ~clr_busy;

  always_comb begin
    arr_addr = A;
    if (clr_busy) begin
      arr_addr = clr_cnt_q;
    end else if (CEN) begin
      arr_addr = addr_hold;
    end
  end

  // Clear sequencer: walks every address once, then parks in IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_CLR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      clr_cnt_q <= clr_cnt_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    clr_cnt_n = clr_cnt_q;
    unique case (state_q)
      ST_CLR: begin
        if (clr_cnt_q == CNT_MAX) begin
          state_n = ST_IDLE;
        end else begin
          clr_cnt_n = clr_cnt_q + CNT_ONE;
        end
      end
      ST_IDLE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n   = ST_CLR;
        clr_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_hold <= '0;
    end else if (~CEN & ~clr_busy) begin
      addr_hold <= A;
    end
  end

  // One storage array per bank; the top bank may be narrower than BANK_WIDTH.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    localparam int LO = b * BANK_WIDTH;
    localparam int HI = ((b + 1) * BANK_WIDTH < DATA_WIDTH) ?
                        (b + 1) * BANK_WIDTH - 1 : DATA_WIDTH - 1;
    localparam int BW = HI - LO + 1;

    logic [BW-1:0] mem [DEPTH];
    logic          we;
    logic [BW-1:0] wdata;

    assign we    = clr_busy | (ext_wr & ~WEN[HI]);
    assign wdata = clr_busy ? '0 : D[HI:LO];

    always_ff @(posedge CLK) begin
      if (we) begin
        mem[arr_addr] <= wdata;
      end
    end

    assign rd_word[HI:LO] = mem[arr_addr];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_q <= '0;
    end else if (ext_rd) begin
      q_q <= rd_word;
    end
  end

`ifdef CT_SPSRAM_OUT_FLOP_EN
  logic                  rd_d;
  logic [DATA_WIDTH-1:0] q_out;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_d  <= 1'b0;
      q_out <= '0;
    end else begin
      rd_d <= ext_rd;
      if (rd_d) begin
        q_out <= q_q;
      end
    end
  end

  assign Q = q_out;
`else
  assign Q = q_q;
`endif

endmodule

// File: tb/tb_ct_f_spsram_param_clr.sv
// Directed self-checking bench for ct_f_spsram_param_clr.
// Covers the default geometry and a 100/32/4 geometry with a partial top bank.
module tb_ct_f_spsram_param_clr;

`ifdef CT_SPSRAM_OUT_FLOP_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cen;
  logic         gwen;
  logic [7:0]   a;
  logic [195:0] d;
  logic [195:0] wen;
  logic [195:0] q;
  logic         busy;

  logic         srst;
  logic         scen;
  logic         sgwen;
  logic [3:0]   sa;
  logic [99:0]  sd;
  logic [99:0]  swen;
  logic [99:0]  sq;
  logic         sbusy;

  int errs;
  int checks;
  int n;
  logic [195:0] m;
  logic [195:0] exp_w;
  logic [99:0]  sm;
  logic [99:0]  sexp;
  logic [99:0]  pat;

  always #5 clk = ~clk;

  ct_f_spsram_param_clr dut (
    .CLK(clk), .RST(rst), .CEN(cen), .GWEN(gwen), .A(a),
    .D(d), .WEN(wen), .Q(q), .CLR_BUSY(busy)
  );

  ct_f_spsram_param_clr #(
    .DATA_WIDTH(100), .ADDR_WIDTH(4), .BANK_WIDTH(32)
  ) sdut (
    .CLK(clk), .RST(srst), .CEN(scen), .GWEN(sgwen), .A(sa),
    .D(sd), .WEN(swen), .Q(sq), .CLR_BUSY(sbusy)
  );

  task automatic chk(input string tag, input logic [195:0] got,
                     input logic [195:0] expv);
    checks++;
    if (got !== expv) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] ad, input logic [195:0] dat,
                    input logic [195:0] wn);
    cen = 1'b0; gwen = 1'b0; a = ad; d = dat; wen = wn;
    tick();
    cen = 1'b1; gwen = 1'b1; wen = '1;
  endtask

  task automatic rd(input logic [7:0] ad);
    cen = 1'b0; gwen = 1'b1; a = ad;
    tick();
    cen = 1'b1;
    repeat (LAT - 1) tick();
  endtask

  task automatic swr(input logic [3:0] ad, input logic [99:0] dat,
                     input logic [99:0] wn);
    scen = 1'b0; sgwen = 1'b0; sa = ad; sd = dat; swen = wn;
    tick();
    scen = 1'b1; sgwen = 1'b1; swen = '1;
  endtask

  task automatic srd(input logic [3:0] ad);
    scen = 1'b0; sgwen = 1'b1; sa = ad;
    tick();
    scen = 1'b1;
    repeat (LAT - 1) tick();
  endtask

  task automatic wait_clr(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_sclr(output int cnt);
    cnt = 0;
    while (sbusy === 1'b1 && cnt < 1000) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    errs = 0; checks = 0;
    rst = 1'b1; cen = 1'b1; gwen = 1'b1; a = '0; d = '0; wen = '1;
    srst = 1'b1; scen = 1'b1; sgwen = 1'b1; sa = '0; sd = '0; swen = '1;
    repeat (3) tick();

    // reset state and clear length
    chk("rst_busy", 196'(busy), 196'(1));
    chk("rst_q", q, '0);
    rst = 1'b0;
    wait_clr(n);
    chk("clr_len", 196'(n), 196'(256));
    rd(8'h00);
    chk("rd_addr0", q, '0);
    rd(8'hFF);
    chk("rd_addr255", q, '0);

    // full write, Q untouched by write, read-after-write
    wr(8'h3C, '1, '0);
    chk("wr_holds_q", q, '0);
    rd(8'h3C);
    chk("raw_3c", q, {196{1'b1}});

    // bank 3 only
    wr(8'h10, '1, '0);
    m = '1; m[191] = 1'b0;
    wr(8'h10, '0, m);
    rd(8'h10);
    exp_w = '1; exp_w[191:144] = '0;
    chk("bank3_only", q, exp_w);

    // partial top bank only
    wr(8'h20, '1, '0);
    m = '1; m[195] = 1'b0;
    wr(8'h20, '0, m);
    rd(8'h20);
    exp_w = '1; exp_w[195:192] = '0;
    chk("top_bank_only", q, exp_w);

    // non-MSB enables are ignored
    m = '0;
    m[47] = 1'b1; m[95] = 1'b1; m[143] = 1'b1; m[191] = 1'b1; m[195] = 1'b1;
    wr(8'h30, '1, m);
    rd(8'h30);
    chk("lsb_wen_ignored", q, '0);

    // Q and addr_hold hold while deselected
    wr(8'h05, 196'd5, '0);
    rd(8'h05);
    chk("rd_05", q, 196'd5);
    cen = 1'b1; gwen = 1'b0; wen = '0; d = '1;
    for (int i = 0; i < 3; i++) begin
      a = (i % 2 == 0) ? 8'h55 : 8'hAA;
      tick();
      chk("q_hold_idle", q, 196'd5);
    end
    chk("addr_hold", 196'(dut.addr_hold), 196'h05);
    gwen = 1'b1; wen = '1;
    rd(8'h55);
    chk("no_wr_deselect", q, '0);

    // reset mid-clear restarts; writes during clear dropped
    rd(8'h3C);
    rst = 1'b1;
    tick();
    chk("rst_async_q", q, '0);
    rst = 1'b0;
    repeat (50) tick();
    wr(8'h77, '1, '0);
    chk("clr_busy_50", 196'(busy), 196'(1));
    chk("clr_q_held", q, '0);
    repeat (49) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clr(n);
    chk("clr_len_restart", 196'(n), 196'(256));
    rd(8'h77);
    chk("dropped_wr", q, '0);
    rd(8'h3C);
    chk("cleared_3c", q, '0);
    rd(8'h05);
    chk("cleared_05", q, '0);

    // small geometry: 100 bits, 32-bit banks, 16 entries
    srst = 1'b0;
    wait_sclr(n);
    chk("s_clr_len", 196'(n), 196'(16));
    srd(4'hF);
    chk("s_rd_top", {96'b0, sq}, '0);
    swr(4'h3, '1, '0);
    sm = '1; sm[99] = 1'b0;
    swr(4'h3, '0, sm);
    srd(4'h3);
    sexp = '1; sexp[99:96] = '0;
    chk("s_top_bank", {96'b0, sq}, {96'b0, sexp});
    pat = {4'hA, 32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C};
    sm = '1; sm[63] = 1'b0;
    swr(4'h7, pat, sm);
    srd(4'h7);
    sexp = {4'h0, 32'h0, 32'h9ABCDEF0, 32'h0};
    chk("s_bank1", {96'b0, sq}, {96'b0, sexp});
    sm = '1; sm[31] = 1'b0;
    swr(4'h9, pat, sm);
    srd(4'h9);
    sexp = {68'h0, 32'h0F1E2D3C};
    chk("s_bank0", {96'b0, sq}, {96'b0, sexp});
    swr(4'hB, pat, '0);
    srd(4'hB);
    chk("s_full", {96'b0, sq}, {96'b0, pat});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
